// File: rtl/butterfly_tw.sv
// Radix-2 butterfly with W8^k twiddle, 3-stage valid/ready pipeline.
// Define BUTTERFLY_SCALE_EN to halve the outputs (floor); default wraps to W bits.
`timescale 1ns/1ps
module butterfly_tw #(
  parameter  int N = 3,
  localparam int W = 2**N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_1_r,
  input  logic [W-1:0] in_1_i,
  input  logic [W-1:0] in_2_r,
  input  logic [W-1:0] in_2_i,
  input  logic [1:0]   tw_k,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_1_r,
  output logic [W-1:0] out_1_i,
  output logic [W-1:0] out_2_r,
  output logic [W-1:0] out_2_i,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int PW = 2*W+2;
  localparam int C  = $rtoi((2.0 ** (W-1)) * 0.70710678 + 0.5);
  localparam logic [PW-1:0] CX = PW'(C);

  logic         v1_q, v2_q, v3_q;
  logic [W-1:0] a1_r_q, a1_i_q, b1_r_q, b1_i_q;
  logic [1:0]   k1_q;
  logic [W-1:0] a2_r_q, a2_i_q;
  logic [W:0]   t2_r_q, t2_i_q;
  logic [W-1:0] o1_r_q, o1_i_q, o2_r_q, o2_i_q;

  logic adv;
  assign adv      = !(v3_q && !out_ready);
  assign in_ready = adv;

  logic [W:0]    br_x, bi_x, sum_x, dif_x;
  logic [W:0]    msum, mdif, t_r_d, t_i_d;
  logic [PW-1:0] psum, pdif;

  assign br_x  = {b1_r_q[W-1], b1_r_q};
  assign bi_x  = {b1_i_q[W-1], b1_i_q};
  assign sum_x = br_x + bi_x;
  assign dif_x = bi_x - br_x;
  assign psum  = {{(W+1){sum_x[W]}}, sum_x} * CX;
  assign pdif  = {{(W+1){dif_x[W]}}, dif_x} * CX;
  // slice == arithmetic shift right by W-1, result always fits W+1 bits
  assign msum  = psum[2*W-1:W-1];
  assign mdif  = pdif[2*W-1:W-1];

  always_comb begin
    t_r_d = br_x;
    t_i_d = bi_x;
    unique case (k1_q)
      2'd0: begin
        t_r_d = br_x;
        t_i_d = bi_x;
      end
      2'd1: begin
        t_r_d = msum;
        t_i_d = mdif;
      end
      2'd2: begin
        t_r_d = bi_x;
        t_i_d = -br_x;
      end
      2'd3: begin
        t_r_d = mdif;
        t_i_d = -msum;
      end
    endcase
  end

  logic [W+1:0] ar_x, ai_x, tr_x, ti_x;
  logic [W+1:0] s1r, s1i, s2r, s2i;
  logic [W-1:0] o1_r_d, o1_i_d, o2_r_d, o2_i_d;

  assign ar_x = {{2{a2_r_q[W-1]}}, a2_r_q};
  assign ai_x = {{2{a2_i_q[W-1]}}, a2_i_q};
  assign tr_x = {t2_r_q[W], t2_r_q};
  assign ti_x = {t2_i_q[W], t2_i_q};
  assign s1r  = ar_x + tr_x;
  assign s1i  = ai_x + ti_x;
  assign s2r  = ar_x - tr_x;
  assign s2i  = ai_x - ti_x;

  logic unused_bits;
`ifdef BUTTERFLY_SCALE_EN
  assign o1_r_d = s1r[W:1];
  assign o1_i_d = s1i[W:1];
  assign o2_r_d = s2r[W:1];
  assign o2_i_d = s2i[W:1];
  assign unused_bits = ^{s1r[W+1], s1r[0], s1i[W+1], s1i[0],
                         s2r[W+1], s2r[0], s2i[W+1], s2i[0],
                         psum[PW-1:2*W], psum[W-2:0],
                         pdif[PW-1:2*W], pdif[W-2:0]};
`else
  assign o1_r_d = s1r[W-1:0];
  assign o1_i_d = s1i[W-1:0];
  assign o2_r_d = s2r[W-1:0];
  assign o2_i_d = s2i[W-1:0];
  assign unused_bits = ^{s1r[W+1:W], s1i[W+1:W],
                         s2r[W+1:W], s2i[W+1:W],
                         psum[PW-1:2*W], psum[W-2:0],
                         pdif[PW-1:2*W], pdif[W-2:0]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      a1_r_q <= '0;
      a1_i_q <= '0;
      b1_r_q <= '0;
      b1_i_q <= '0;
      k1_q   <= '0;
      a2_r_q <= '0;
      a2_i_q <= '0;
      t2_r_q <= '0;
      t2_i_q <= '0;
      o1_r_q <= '0;
      o1_i_q <= '0;
      o2_r_q <= '0;
      o2_i_q <= '0;
    end else if (adv) begin
      v1_q   <= in_valid;
      a1_r_q <= in_1_r;
      a1_i_q <= in_1_i;
      b1_r_q <= in_2_r;
      b1_i_q <= in_2_i;
      k1_q   <= tw_k;
      v2_q   <= v1_q;
      a2_r_q <= a1_r_q;
      a2_i_q <= a1_i_q;
      t2_r_q <= t_r_d;
      t2_i_q <= t_i_d;
      v3_q   <= v2_q;
      o1_r_q <= o1_r_d;
      o1_i_q <= o1_i_d;
      o2_r_q <= o2_r_d;
      o2_i_q <= o2_i_d;
    end
  end

  assign out_valid = v3_q;
  assign out_1_r   = o1_r_q;
  assign out_1_i   = o1_i_q;
  assign out_2_r   = o2_r_q;
  assign out_2_i   = o2_i_q;

endmodule

// File: tb/tb_butterfly_tw.sv
// Self-checking bench for butterfly_tw (N=3, W=8) with an arithmetic reference model.
// Honours BUTTERFLY_SCALE_EN when compiled with it.
`timescale 1ns/1ps
module tb_butterfly_tw;
  localparam int N = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_1_r, in_1_i, in_2_r, in_2_i;
  logic [1:0]   tw_k;
  logic         in_valid, in_ready;
  logic [W-1:0] out_1_r, out_1_i, out_2_r, out_2_i;
  logic         out_valid, out_ready;
  logic [31:0]  outs;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  butterfly_tw #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_1_r(in_1_r), .in_1_i(in_1_i),
    .in_2_r(in_2_r), .in_2_i(in_2_i),
    .tw_k(tw_k),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_1_r(out_1_r), .out_1_i(out_1_i),
    .out_2_r(out_2_r), .out_2_i(out_2_i),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  assign outs = {out_1_r, out_1_i, out_2_r, out_2_i};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic int fdiv(input int x, input int d);
    return (x >= 0) ? x / d : -((-x + d - 1) / d);
  endfunction

  // Complex a + W8^k*b and a - W8^k*b with C = 91/128
  function automatic logic [31:0] model(input logic [7:0] ar, ai, br, bi,
                                        input logic [1:0] k);
    int a_r, a_i, b_r, b_i, tr, ti;
    int o[4];
    a_r = int'($signed(ar));
    a_i = int'($signed(ai));
    b_r = int'($signed(br));
    b_i = int'($signed(bi));
    case (k)
      2'd0: begin tr = b_r; ti = b_i; end
      2'd1: begin
        tr = fdiv(91 * (b_r + b_i), 128);
        ti = fdiv(91 * (b_i - b_r), 128);
      end
      2'd2: begin tr = b_i; ti = -b_r; end
      default: begin
        tr = fdiv(91 * (b_i - b_r), 128);
        ti = -fdiv(91 * (b_r + b_i), 128);
      end
    endcase
    o[0] = a_r + tr;
    o[1] = a_i + ti;
    o[2] = a_r - tr;
    o[3] = a_i - ti;
`ifdef BUTTERFLY_SCALE_EN
    for (int j = 0; j < 4; j++) o[j] = fdiv(o[j], 2);
`endif
    return {8'(o[0]), 8'(o[1]), 8'(o[2]), 8'(o[3])};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic v);
    in_valid = v;
    in_1_r = 8'($urandom);
    in_1_i = 8'($urandom);
    in_2_r = 8'($urandom);
    in_2_i = 8'($urandom);
    tw_k   = 2'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    out_ready = 1'b1;
    drive_rand(1'b1);
    tick();
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b exp 0", out_valid);
    end
    n_chk++;
    if (outs !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h exp 00000000", outs);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b exp 1", in_ready);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    int ar[3] = '{10, 100, 0};
    int ai[3] = '{20, 0, 0};
    int br[3] = '{64, 100, 5};
    int bi[3] = '{0, 0, 7};
    int kk[3] = '{1, 0, 2};
`ifdef BUTTERFLY_SCALE_EN
    int ex[3][4] = '{'{27, -13, -18, 33}, '{100, 0, 0, 0}, '{3, -3, -4, 2}};
`else
    int ex[3][4] = '{'{55, -26, -35, 66}, '{-56, 0, 0, 0}, '{7, -5, -7, 5}};
`endif
    logic [31:0] ev;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ev = {8'(ex[i][0]), 8'(ex[i][1]), 8'(ex[i][2]), 8'(ex[i][3])};
      in_1_r = 8'(ar[i]);
      in_1_i = 8'(ai[i]);
      in_2_r = 8'(br[i]);
      in_2_i = 8'(bi[i]);
      tw_k   = 2'(kk[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int e = 1; e < 3; e++) begin
        n_chk++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL vec%0d_early_valid edge%0d: got %b exp 0", i, e, out_valid);
        end
        tick();
      end
      n_chk++;
      if (out_valid !== 1'b1 || outs !== ev) begin
        n_fail++;
        $display("FAIL vec%0d_result: got v=%b %h exp v=1 %h", i, out_valid, outs, ev);
      end
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_retire: got %b exp 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [7:0] opa_r[6], opa_i[6], opb_r[6], opb_i[6];
    logic [1:0] opk[6];
    logic [31:0] frozen, ev;
    int sent = 0, got = 0, stall_left = 0;
    bit stalled = 0;
    for (int i = 0; i < 6; i++) begin
      opa_r[i] = 8'($urandom);
      opa_i[i] = 8'($urandom);
      opb_r[i] = 8'($urandom);
      opb_i[i] = 8'($urandom);
      opk[i]   = 2'($urandom);
    end
    exp_q.delete();
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      if (!stalled && out_valid) begin
        stalled = 1;
        stall_left = 4;
        frozen = outs;
      end
      out_ready = (stall_left == 0);
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_1_r = opa_r[sent];
        in_1_i = opa_i[sent];
        in_2_r = opb_r[sent];
        in_2_i = opb_i[sent];
        tw_k   = opk[sent];
      end
      #1;
      if (stall_left > 0) begin
        n_chk++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready: got %b exp 0", in_ready);
        end
        n_chk++;
        if (out_valid !== 1'b1 || outs !== frozen) begin
          n_fail++;
          $display("FAIL stall_frozen: got v=%b %h exp v=1 %h", out_valid, outs, frozen);
        end
        stall_left--;
      end
      if (out_valid && out_ready) begin
        ev = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_chk++;
        if (outs !== ev) begin
          n_fail++;
          $display("FAIL b2b_result%0d: got %h exp %h", got, outs, ev);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_1_r, in_1_i, in_2_r, in_2_i, tw_k));
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_chk++;
    if (got != 6 || sent != 6 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d sent %0d left %0d exp 6 6 0", got, sent, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] ev;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive_rand($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (cyc >= 360) begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      n_chk++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_fail++;
        $display("FAIL rand_in_ready: got %b exp %b", in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        ev = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_chk++;
        if (outs !== ev) begin
          n_fail++;
          $display("FAIL rand_result cyc%0d: got %h exp %h", cyc, outs, ev);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_1_r, in_1_i, in_2_r, in_2_i, tw_k));
      tick();
    end
    n_chk++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_drain: got left=%0d v=%b exp 0 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] ev;
    out_ready = 1'b0;
    drive_rand(1'b1);
    tick();
    drive_rand(1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre_valid: got %b exp 1", out_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || outs !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_clear: got v=%b %h exp v=0 00000000", out_valid, outs);
    end
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_ghost c%0d: got %b exp 0", c, out_valid);
      end
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive_rand(1'b1);
    ev = model(in_1_r, in_1_i, in_2_r, in_2_i, tw_k);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || outs !== ev) begin
      n_fail++;
      $display("FAIL first_accept: got v=%b %h exp v=1 %h", out_valid, outs, ev);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_1_r = '0;
    in_1_i = '0;
    in_2_r = '0;
    in_2_i = '0;
    tw_k = '0;
    #2;
    test_reset();
    test_vectors();
    test_back_to_back_stall();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/butterfly_tw.md
BUTTERFLY_TW -- requirements
Module: butterfly_tw

Interface
REQ-001 SHALL have parameter N, default 3, data width W = 2**N bits, two's complement.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports in_1_r, in_1_i  input  W  operand a (real, imag).
REQ-005 SHALL have ports in_2_r, in_2_i  input  W  operand b (real, imag).
REQ-006 SHALL have port tw_k  input  2  twiddle index k; twiddle = W8^k, W8 = (1-i)/sqrt2.
REQ-007 SHALL have port in_valid  input  1  operands/tw_k valid.
REQ-008 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-009 SHALL have ports out_1_r, out_1_i, out_2_r, out_2_i  output  W  results.
REQ-010 SHALL have port out_valid  output  1  results valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts results.

Function
REQ-012 SHALL compute t = W8^k * b, out_1 = a + t, out_2 = a - t.
REQ-013 SHALL form t as: k=0 (br, bi); k=1 (C*(br+bi), C*(bi-br)); k=2 (bi, -br); k=3 (C*(bi-br), -C*(br+bi)).
REQ-014 SHALL use C = round(2**(W-1) * 0.70710678) (91 for W=8); product = full-precision sum * C, arithmetic shift right by W-1 (floor).
REQ-015 SHALL hold sums/differences at W+1 bits before multiply and final add/sub at W+2 bits; no intermediate overflow.
REQ-016 SHALL be a 3-stage pipeline: S1 registers a, b, k; S2 registers a, t; S3 registers outputs.
REQ-017 SHALL accept a transfer on a rising edge when in_valid && in_ready.
REQ-018 SHALL assert out_valid with results exactly 3 edges after acceptance when out_ready stays high.
REQ-019 SHALL drive in_ready = !(out_valid && !out_ready) combinationally.
REQ-020 SHALL freeze all stages (data and valid bits) while out_valid && !out_ready; outputs stable during stall.
REQ-021 SHALL propagate bubbles: a stage with valid=0 advances freely; back-to-back accepts give one result per cycle.
REQ-022 SHALL retire a result on the edge where out_valid && out_ready; simultaneous retire and accept sustain full throughput.
REQ-023 SHALL not let in_valid/tw_k change the pipeline when in_ready=0.

Reset
REQ-024 SHALL, on rst=0, asynchronously clear all stage valid bits, out_valid, and all data registers/outputs to 0.
REQ-025 SHALL discard in-flight operations on reset mid-operation; none appear after release.
REQ-026 SHALL accept a transfer on the first rising edge after rst releases.

Configuration
REQ-027 SHALL with BUTTERFLY_SCALE_EN defined output bits [W:1] of the W+2-bit results (arithmetic /2, floor).
REQ-028 SHALL without BUTTERFLY_SCALE_EN output bits [W-1:0] (wrap modulo 2**W).

Verification (N=3, W=8)
REQ-029 SHALL check k=1, a=(10,20), b=(64,0), no scale -> 3 cycles later out_1=(55,-26), out_2=(-35,66).
REQ-030 SHALL check k=0, a=(100,0), b=(100,0) -> no scale out_1_r=-56, out_2_r=0; with BUTTERFLY_SCALE_EN out_1_r=100, out_2_r=0.
REQ-031 SHALL check k=2, a=(0,0), b=(5,7) -> out_1=(7,-5), out_2=(-7,5).
REQ-032 SHALL stream 6 back-to-back inputs, hold out_ready=0 for 4 cycles after first out_valid -> in_ready=0 during stall, outputs frozen, all 6 results in order, none lost or duplicated.
REQ-033 SHALL pulse rst=0 with 2 ops in flight -> outputs and out_valid 0 immediately; no result emitted after release.
